fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Sequences the IF stage: owns the fetch PC, drives inst SRAM address/enable, and
//  holds fetched instructions while decode stalls (skid buffer). Chooses next PC
//  among exception, eret, branch and sequential PC+4. Sits between inst SRAM and
//  decode, in front of the plain PC register.
// PARAMETERS
//  RESET_PC  32'hbfc00000  boot fetch address
//  EXC_PC    32'hbfc00380  general exception entry
// PORTS
//  clk              in   1   clock
//  resetn           in   1   reset, synchronous, active-low
//  de_allowin       in   1   decode accepts fs instruction this cycle
//  br_taken         in   1   branch redirect pulse from decode (1 cycle)
//  br_target        in   32  branch target
//  exc_valid        in   1   exception flush from WB (1 cycle)
//  eret_valid       in   1   eret flush from WB (1 cycle)
//  epc              in   32  eret return address
//  inst_sram_en     out  1   SRAM read enable
//  inst_sram_addr   out  32  SRAM read address (= nextpc)
//  inst_sram_rdata  in   32  SRAM data, valid 1 cycle after en
//  fs_valid         out  1   fs_pc/fs_inst hold a live instruction
//  fs_pc            out  32  PC of instruction in fetch
//  fs_inst          out  32  instruction in fetch
// BEHAVIOUR
//  - Reset: state=BOOT, fs_valid=0, fs_pc=RESET_PC, buf_valid=0, buf=0, br_pend=0.
//  - SRAM: synchronous, 1-cycle read latency; addr/en combinational from state.
//  - States BOOT, RUN, STALL.
//    BOOT: en=1, addr=RESET_PC; next: fs_pc<=RESET_PC, fs_valid<=1, ->RUN.
//    RUN & de_allowin: en=1, addr=nextpc, fs_pc<=nextpc, fs_valid<=1.
//    RUN & !de_allowin: en=0, buf<=rdata, buf_valid<=1, ->STALL.
//    STALL: en=0, fs_inst=buf; on de_allowin: en=1, addr=nextpc, fs_pc<=nextpc,
//      buf_valid<=0, ->RUN.
//  - nextpc priority: exc_valid->EXC_PC > eret_valid->epc > br_taken->br_target
//    > br_pend->br_tgt_q > fs_pc+4 (32-bit wrap, no carry out).
//  - fs_inst = buf_valid ? buf : inst_sram_rdata.
//  - Flush (exc_valid|eret_valid) in any state except BOOT: takes effect
//    immediately regardless of de_allowin: en=1, addr=target, fs_pc<=target,
//    fs_valid<=1, buf_valid<=0, br_pend<=0, ->RUN. Both high: exc wins.
//  - br_taken while !de_allowin: br_pend<=1, br_tgt_q<=br_target; applied at the
//    next advance, then cleared. br_taken with de_allowin: applied same cycle.
//  - Flush during BOOT ignored (no instruction in flight).
//  - resetn low mid-operation: all state back to reset values next edge;
//    buffered inst and pending branch discarded.
//  - Delay slot: instruction in fetch when br_taken fires is kept (MIPS delay slot).
// STRUCTURE
//  - Shared package/header: RESET_PC, EXC_PC, state encodings (2-bit).
//  - One sub-module natural: fetch_skid_buf (32-bit buf + buf_valid, capture/clear).
//  - nextpc mux and FSM remain in fetch_pc_ctrl.
// TESTING
//  1 Reset then allowin=1: addr BOOT=bfc00000; fs_pc bfc00000,bfc00004,bfc00008 with
//    fs_inst = SRAM words, fs_valid=1 from cycle 2.
//  2 Stall 3 cycles at fs_pc bfc00008: en=0, fs_inst stable = word@bfc00008;
//    release -> fs_pc bfc0000c next edge, no dropped/duplicated inst.
//  3 br_taken, target 80001000, allowin=1: addr=80001000 same cycle;
//    fs_pc=80001000 next edge.
//  4 br_taken during stall, target 80002000: held; on release fs_pc=80002000.
//  5 exc_valid and eret_valid together while stalled, epc=80003000:
//    fs_pc=bfc00380 next edge, buffer and pending branch cleared.
//  6 resetn low while in STALL with br_pend=1: next edges replay case 1 exactly.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_pkg
// Purpose  : Shared constants, state encoding and helpers for the IF-stage
//            PC sequencer (boot/exception vectors, 2-bit FSM states).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] FETCH_EXC_PC   = 32'hbfc0_0380;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  // Sequential successor; the adder wraps at 32 bits, carry out is dropped.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_if
// Purpose  : Bundles the fetch-stage signals: decode/WB redirect inputs,
//            instruction SRAM port and the fetch-stage instruction outputs.
// Ports    : master - fetch controller side (drives SRAM en/addr, fs_*)
//            slave  - surroundings (decode, WB, SRAM) side
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if;

  logic        de_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  modport master (
    input  de_allowin, br_taken, br_target, exc_valid, eret_valid, epc,
    input  inst_sram_rdata,
    output inst_sram_en, inst_sram_addr,
    output fs_valid, fs_pc, fs_inst
  );

  modport slave (
    output de_allowin, br_taken, br_target, exc_valid, eret_valid, epc,
    output inst_sram_rdata,
    input  inst_sram_en, inst_sram_addr,
    input  fs_valid, fs_pc, fs_inst
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Purpose  : One-entry holding register for the fetched instruction while
//            decode stalls. Clear has priority over capture.
// Ports    : clk, resetn (sync, active-low)
//            capture  in  1   load din, mark valid
//            clear    in  1   drop the held word
//            din      in  32  SRAM read data
//            buf_valid out 1  holding register is live
//            buf_data out 32  held instruction
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        capture,
  input  wire logic        clear,
  input  wire logic [31:0] din,
  output logic             buf_valid,
  output logic [31:0]      buf_data
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'd0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_data  <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : IF-stage sequencer. Owns the fetch PC, drives the inst SRAM
//            address/enable, selects the next PC (exception > eret > branch >
//            pending branch > PC+4) and holds the fetched word while decode
//            stalls.
// Ports    : clk     in  1  clock
//            resetn  in  1  reset, synchronous, active-low
//            bus     master modport of fetch_pc_ctrl_if (redirect inputs,
//                    SRAM en/addr/rdata, fs_valid/fs_pc/fs_inst)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] EXC_PC   = FETCH_EXC_PC
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  fetch_pc_ctrl_if.master bus
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0] fs_pc_q;
  logic        fs_valid_q;
  logic        br_pend;
  logic [31:0] br_tgt_q;

  logic [31:0] nextpc;
  logic        flush;
  logic        advance;
  logic        buf_capture;
  logic        buf_clear;
  logic        buf_valid;
  logic [31:0] buf_data;

  // No instruction is in flight during BOOT, so redirects there are ignored.
  assign flush = (bus.exc_valid | bus.eret_valid) & (state != ST_BOOT);

  always_comb begin
    nextpc = seq_pc(fs_pc_q);
    if (bus.exc_valid)       nextpc = EXC_PC;
    else if (bus.eret_valid) nextpc = bus.epc;
    else if (bus.br_taken)   nextpc = bus.br_target;
    else if (br_pend)        nextpc = br_tgt_q;
  end

  // Next-state and SRAM control. "advance" means fs_pc moves to nextpc at
  // the coming edge and a new SRAM read is issued for it.
  always_comb begin
    state_nxt          = state;
    bus.inst_sram_en   = 1'b0;
    bus.inst_sram_addr = nextpc;
    advance            = 1'b0;
    buf_capture        = 1'b0;
    buf_clear          = 1'b0;
    case (state)
      ST_BOOT: begin
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = RESET_PC;
        state_nxt          = ST_RUN;
      end
      ST_RUN: begin
        if (flush || bus.de_allowin) begin
          bus.inst_sram_en = 1'b1;
          advance          = 1'b1;
          buf_clear        = 1'b1;
        end else begin
          // SRAM data is only valid this cycle; park it for the stall.
          buf_capture = 1'b1;
          state_nxt   = ST_STALL;
        end
      end
      ST_STALL: begin
        if (flush || bus.de_allowin) begin
          bus.inst_sram_en = 1'b1;
          advance          = 1'b1;
          buf_clear        = 1'b1;
          state_nxt        = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_BOOT;
      fs_pc_q    <= RESET_PC;
      fs_valid_q <= 1'b0;
      br_pend    <= 1'b0;
      br_tgt_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_BOOT) begin
        fs_pc_q    <= RESET_PC;
        fs_valid_q <= 1'b1;
      end else if (advance) begin
        fs_pc_q    <= nextpc;
        fs_valid_q <= 1'b1;
      end
      // An advance consumes (or a flush discards) any pending branch. A
      // branch that cannot be applied now is remembered; the instruction
      // currently in fetch is its delay slot and stays put.
      if (advance) begin
        br_pend <= 1'b0;
      end else if (bus.br_taken && (state != ST_BOOT)) begin
        br_pend  <= 1'b1;
        br_tgt_q <= bus.br_target;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .din       (bus.inst_sram_rdata),
    .buf_valid (buf_valid),
    .buf_data  (buf_data)
  );

  assign bus.fs_valid = fs_valid_q;
  assign bus.fs_pc    = fs_pc_q;
  assign bus.fs_inst  = buf_valid ? buf_data : bus.inst_sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_ctrl
// Purpose  : Self-checking bench for fetch_pc_ctrl. A stimulus thread applies
//            directed cycles and queues the (pc, inst) pairs decode should
//            receive; a monitor pops and compares on every accepted issue.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t expq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Instruction memory contents as a fixed function of address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0f0f_0f0f;
  endfunction

  // Synchronous SRAM; returns junk when not enabled so a missing skid
  // buffer shows up.
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? memw(bus.inst_sram_addr) : 32'hdead_beef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    expq.push_back('{pc: pc, inst: memw(pc)});
  endtask

  // One clock: inputs change just after the edge, return at the negedge.
  task automatic cyc(input logic alw, input logic br, input logic [31:0] tgt,
                     input logic ex, input logic er, input logic rn);
    @(posedge clk);
    #1;
    bus.de_allowin = alw;
    bus.br_taken   = br;
    bus.br_target  = tgt;
    bus.exc_valid  = ex;
    bus.eret_valid = er;
    resetn         = rn;
    @(negedge clk);
  endtask

  // Monitor: every instruction decode accepts must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && bus.fs_valid === 1'b1 && bus.de_allowin === 1'b1) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_issue: got pc %08h expected none", bus.fs_pc);
        end else begin
          mon_e = expq.pop_front();
          chk("issue_pc", bus.fs_pc, mon_e.pc);
          chk("issue_inst", bus.fs_inst, mon_e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    bus.de_allowin = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'd0;
    bus.exc_valid  = 1'b0;
    bus.eret_valid = 1'b0;
    bus.epc        = 32'h8000_3000;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_fs_valid", {31'd0, bus.fs_valid}, 32'd0);
    chk("rst_fs_pc", bus.fs_pc, 32'hbfc0_0000);
    chk("rst_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("rst_addr", bus.inst_sram_addr, 32'hbfc0_0000);

    // Case 1: boot and sequential fetch; a flush during BOOT is ignored.
    push(32'hbfc0_0000);
    push(32'hbfc0_0004);
    push(32'hbfc0_0008);
    cyc(1, 0, 0, 1, 0, 1);                          // C0 BOOT
    chk("boot_addr", bus.inst_sram_addr, 32'hbfc0_0000);
    chk("boot_en", {31'd0, bus.inst_sram_en}, 32'd1);
    cyc(1, 0, 0, 0, 0, 1);                          // C1
    chk("c1_addr", bus.inst_sram_addr, 32'hbfc0_0004);
    chk("c1_fs_valid", {31'd0, bus.fs_valid}, 32'd1);
    cyc(1, 0, 0, 0, 0, 1);                          // C2

    // Case 2: three-cycle stall at bfc00008.
    for (int i = 0; i < 3; i++) begin               // C3..C5
      cyc(0, 0, 0, 0, 0, 1);
      chk("stall_en", {31'd0, bus.inst_sram_en}, 32'd0);
      chk("stall_pc", bus.fs_pc, 32'hbfc0_0008);
      chk("stall_inst", bus.fs_inst, memw(32'hbfc0_0008));
    end
    push(32'hbfc0_000c);
    cyc(1, 0, 0, 0, 0, 1);                          // C6 release
    chk("release_addr", bus.inst_sram_addr, 32'hbfc0_000c);
    chk("release_en", {31'd0, bus.inst_sram_en}, 32'd1);

    // Case 3: branch with allowin; delay slot bfc0000c still issues.
    push(32'h8000_1000);
    cyc(1, 1, 32'h8000_1000, 0, 0, 1);              // C7
    chk("br_addr", bus.inst_sram_addr, 32'h8000_1000);
    push(32'h8000_1004);
    cyc(1, 0, 0, 0, 0, 1);                          // C8
    chk("br_fs_pc", bus.fs_pc, 32'h8000_1000);

    // Case 4: branch while stalled is held until release.
    cyc(0, 1, 32'h8000_2000, 0, 0, 1);              // C9
    cyc(0, 0, 0, 0, 0, 1);                          // C10
    chk("pend_inst", bus.fs_inst, memw(32'h8000_1004));
    cyc(1, 0, 0, 0, 0, 1);                          // C11
    chk("pend_addr", bus.inst_sram_addr, 32'h8000_2000);
    cyc(0, 1, 32'h8000_4000, 0, 0, 1);              // C12
    chk("pend_fs_pc", bus.fs_pc, 32'h8000_2000);

    // Case 5: exc and eret together while stalled, branch pending.
    cyc(0, 0, 0, 1, 1, 1);                          // C13
    chk("exc_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("exc_addr", bus.inst_sram_addr, 32'hbfc0_0380);
    push(32'hbfc0_0380);
    cyc(1, 0, 0, 0, 0, 1);                          // C14
    chk("exc_fs_pc", bus.fs_pc, 32'hbfc0_0380);
    chk("exc_next_addr", bus.inst_sram_addr, 32'hbfc0_0384);

    // Case 6: reset while stalled with a pending branch, then replay case 1.
    cyc(0, 1, 32'h8000_5000, 0, 0, 1);              // C15
    cyc(0, 0, 0, 0, 0, 0);                          // C16
    cyc(1, 0, 0, 0, 0, 1);                          // C17 BOOT
    chk("rst2_fs_valid", {31'd0, bus.fs_valid}, 32'd0);
    chk("rst2_fs_pc", bus.fs_pc, 32'hbfc0_0000);
    chk("rst2_addr", bus.inst_sram_addr, 32'hbfc0_0000);
    push(32'hbfc0_0000);
    push(32'hbfc0_0004);
    push(32'hbfc0_0008);
    cyc(1, 0, 0, 0, 0, 1);                          // C18
    chk("rst2_c1_addr", bus.inst_sram_addr, 32'hbfc0_0004);
    cyc(1, 0, 0, 0, 0, 1);                          // C19
    cyc(1, 0, 0, 0, 0, 1);                          // C20
    cyc(0, 0, 0, 0, 0, 1);                          // C21

    chk("queue_left", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
